// File: rtl/prio_disp_pkg.sv
// Shared types, 7-segment codes and helpers for the priority-encoder display scanner.
package prio_disp_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic int unsigned pow10(input int n);
    int unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/prio_disp_scan_seg7_dec.sv
// Combinational BCD-plus-blank to 7-segment decoder (seg[0]=a .. seg[6]=g).
import prio_disp_pkg::*;

module seg7_dec (
  input  bcd_t       digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/prio_disp_scan.sv
// Priority encoder with registered code/gs and a multiplexed decimal 7-segment display.
// Define PRIO_DISP_HOLD_EN to keep showing the last winner after requests go away.
import prio_disp_pkg::*;

module prio_disp_scan #(
  parameter  int N_IN     = 8,
  parameter  int DIGITS   = 2,
  parameter  int SCAN_DIV = 1000,
  localparam int CODE_W   = $clog2(N_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ei_n,
  input  logic [N_IN-1:0]   i_n,
  output logic [CODE_W-1:0] code,
  output logic              gs,
  output logic              chg,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] dig_en
);

  localparam int          IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int          PRE_W   = $clog2(SCAN_DIV);
  localparam int unsigned MAX_VAL = pow10(DIGITS) - 1;

  logic [N_IN-1:0]   req;
  logic [CODE_W-1:0] win;
  logic              any;
  logic [CODE_W-1:0] disp_code, disp_prev;
  logic              disp_valid;

  assign req = ~i_n & {N_IN{~ei_n}};

  // Later (higher) indices overwrite lower ones, so the top request wins.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      if (req[k]) begin
        win = CODE_W'(k);
        any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code       <= '0;
      gs         <= 1'b0;
      disp_code  <= '0;
      disp_prev  <= '0;
      disp_valid <= 1'b0;
      chg        <= 1'b0;
    end else begin
      code      <= win;
      gs        <= any;
      disp_prev <= disp_code;
      chg       <= (disp_code != disp_prev);
      if (any) disp_code <= win;
`ifdef PRIO_DISP_HOLD_EN
      if (any) disp_valid <= 1'b1;
`else
      disp_valid <= any;
`endif
    end
  end

  int unsigned sat_val;
  bcd_t        digs [DIGITS];
  logic [DIGITS-1:0] lead_zero;

  // Divisors are constant per unrolled digit, so this stays a fixed network.
  always_comb begin
    sat_val = (32'(disp_code) > MAX_VAL) ? MAX_VAL : 32'(disp_code);
    for (int d = 0; d < DIGITS; d++) begin
      digs[d]      = bcd_t'((sat_val / pow10(d)) % 10);
      lead_zero[d] = (d > 0) && (sat_val < pow10(d));
    end
  end

  logic [PRE_W-1:0] pre;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             wrap;
  bcd_t             cur_dig;
  logic             cur_blank;
  logic [6:0]       seg_nxt;

  assign wrap = (pre == PRE_W'(SCAN_DIV - 1));

  always_comb begin
    idx_nxt = idx;
    if (DIGITS > 1 && wrap)
      idx_nxt = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
  end

  assign cur_dig   = digs[idx];
  assign cur_blank = !disp_valid || lead_zero[idx];

  seg7_dec u_dec (
    .digit (cur_dig),
    .blank (cur_blank),
    .seg   (seg_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre    <= '0;
      idx    <= '0;
      dig_en <= DIGITS'(1);
      seg    <= SEG_BLANK;
    end else begin
      pre    <= wrap ? '0 : pre + 1'b1;
      idx    <= idx_nxt;
      dig_en <= DIGITS'(1) << idx_nxt;
      seg    <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_prio_disp_scan.sv
// Directed self-checking bench: encoder vector table plus scan, strobe, blanking, reset and saturation sequences.
module tb_prio_disp_scan;

  logic         clk = 1'b0;
  logic         rst;
  logic         ei_n, ei_n2;
  logic [7:0]   i_n;
  logic [127:0] i_n2;
  logic [2:0]   code;
  logic [6:0]   code2;
  logic         gs, gs2, chg, chg2;
  logic [6:0]   seg, seg2;
  logic [1:0]   dig_en, dig_en2;

  int n_checks = 0;
  int n_fail   = 0;

  prio_disp_scan #(.N_IN(8), .DIGITS(2), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .ei_n(ei_n), .i_n(i_n), .code(code), .gs(gs),
    .chg(chg), .seg(seg), .dig_en(dig_en)
  );

  prio_disp_scan #(.N_IN(128), .DIGITS(2), .SCAN_DIV(4)) dut_sat (
    .clk(clk), .rst(rst), .ei_n(ei_n2), .i_n(i_n2), .code(code2), .gs(gs2),
    .chg(chg2), .seg(seg2), .dig_en(dig_en2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits until the wanted digit has been selected for two edges, then checks its segments.
  task automatic check_seg(input int inst, input logic [1:0] want, input logic [6:0] exp,
                           input string name);
    int         cnt;
    logic [1:0] d;
    logic [6:0] s;
    cnt = 0;
    s   = 7'h00;
    for (int k = 0; k < 24 && cnt < 2; k++) begin
      @(posedge clk); #1;
      d = (inst == 0) ? dig_en : dig_en2;
      s = (inst == 0) ? seg : seg2;
      cnt = (d == want) ? cnt + 1 : 0;
    end
    if (cnt < 2) chk({name, "_timeout"}, 32'(cnt), 32'd2);
    else         chk(name, 32'(s), 32'(exp));
  endtask

  typedef struct {
    logic       ei_n;
    logic [7:0] i_n;
    logic [2:0] code;
    logic       gs;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int         cnt;
    logic [1:0] prev_en;
    bit         found;

    vecs[0] = '{1'b0, 8'hFF, 3'd0, 1'b0};
    vecs[1] = '{1'b0, 8'hFE, 3'd0, 1'b1};
    vecs[2] = '{1'b0, 8'hAF, 3'd6, 1'b1};
    vecs[3] = '{1'b0, 8'h7F, 3'd7, 1'b1};
    vecs[4] = '{1'b0, 8'hF7, 3'd3, 1'b1};
    vecs[5] = '{1'b1, 8'h00, 3'd0, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 3'd7, 1'b1};
    vecs[7] = '{1'b0, 8'hFD, 3'd1, 1'b1};

    rst = 1'b1; ei_n = 1'b1; i_n = 8'hFF; ei_n2 = 1'b1; i_n2 = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_gs", 32'(gs), 32'd0);
    chk("rst_chg", 32'(chg), 32'd0);
    chk("rst_seg", 32'(seg), 32'h00);
    chk("rst_dig_en", 32'(dig_en), 32'b01);

    // Scan after reset release: 4 cycles per digit, then wrap.
    @(negedge clk); rst = 1'b0; #1;
    chk("scan_c0", 32'(dig_en), 32'b01);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("scan_c%0d", k), 32'(dig_en), (k < 4) ? 32'b01 : (k < 8) ? 32'b10 : 32'b01);
    end

    foreach (vecs[i]) begin
      @(negedge clk); ei_n = vecs[i].ei_n; i_n = vecs[i].i_n;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_code", i), 32'(code), 32'(vecs[i].code));
      chk($sformatf("vec%0d_gs", i), 32'(gs), 32'(vecs[i].gs));
    end

    // Priority case on the display: 6 on units, tens blanked.
    @(negedge clk); ei_n = 1'b0; i_n = 8'b1010_1111;
    @(posedge clk); #1;
    chk("prio_code", 32'(code), 32'd6);
    chk("prio_gs", 32'(gs), 32'd1);
    check_seg(0, 2'b01, 7'h7D, "prio_units");
    check_seg(0, 2'b10, 7'h00, "prio_tens");

    // Change strobe 6 -> 3: one-cycle pulse, one cycle after the display register changes.
    @(negedge clk); i_n = 8'hF7;
    @(posedge clk); #1; chk("chg_e0", 32'(chg), 32'd0);
    @(posedge clk); #1; chk("chg_e1", 32'(chg), 32'd1);
    @(posedge clk); #1; chk("chg_e2", 32'(chg), 32'd0);

    @(negedge clk); i_n = 8'hFF;
    repeat (3) @(negedge clk);
    i_n = 8'hF7;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (chg) cnt++;
    end
    chk("rechg_count", 32'(cnt), 32'd0);
    chk("rechg_code", 32'(code), 32'd3);

    // Disable wins over a full request set.
    @(negedge clk); ei_n = 1'b1; i_n = 8'h00;
    @(posedge clk); #1;
    chk("dis_gs", 32'(gs), 32'd0);
    cnt = chg ? 1 : 0;
    @(posedge clk); #1;
    if (chg) cnt++;
`ifndef PRIO_DISP_HOLD_EN
    chk("dis_blank_2cyc", 32'(seg), 32'h00);
`endif
    chk("dis_no_chg", 32'(cnt), 32'd0);
`ifdef PRIO_DISP_HOLD_EN
    check_seg(0, 2'b01, 7'h4F, "dis_units");
`else
    check_seg(0, 2'b01, 7'h00, "dis_units");
`endif
    check_seg(0, 2'b10, 7'h00, "dis_tens");

    // Reset while the tens digit is selected and the prescaler sits at 2.
    @(negedge clk); ei_n = 1'b0; i_n = 8'hAF;
    found   = 1'b0;
    prev_en = dig_en;
    for (int k = 0; k < 24 && !found; k++) begin
      @(posedge clk); #1;
      if (prev_en == 2'b01 && dig_en == 2'b10) found = 1'b1;
      prev_en = dig_en;
    end
    chk("mid_find", 32'(found), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_pre_code", 32'(code), 32'd6);
    rst = 1'b1;
    #1;
    chk("mid_dig_en", 32'(dig_en), 32'b01);
    chk("mid_seg", 32'(seg), 32'h00);
    chk("mid_code", 32'(code), 32'd0);
    chk("mid_gs", 32'(gs), 32'd0);
    @(negedge clk); rst = 1'b0; ei_n = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 20 && cnt == 0; k++) begin
      @(posedge clk); #1;
      if (dig_en == 2'b10) cnt = k;
    end
    chk("mid_first_adv", 32'(cnt), 32'd4);

    // Wide instance: saturation and two-digit decoding.
    @(negedge clk); ei_n2 = 1'b0; i_n2 = '1; i_n2[127] = 1'b0;
    @(posedge clk); #1;
    chk("sat_code", 32'(code2), 32'd127);
    chk("sat_gs", 32'(gs2), 32'd1);
    check_seg(1, 2'b01, 7'h6F, "sat_units");
    check_seg(1, 2'b10, 7'h6F, "sat_tens");

    @(negedge clk); i_n2 = '1; i_n2[100] = 1'b0;
    @(posedge clk); #1;
    chk("sat100_code", 32'(code2), 32'd100);
    check_seg(1, 2'b10, 7'h6F, "sat100_tens");

    @(negedge clk); i_n2 = '1; i_n2[42] = 1'b0;
    @(posedge clk); #1;
    chk("v42_code", 32'(code2), 32'd42);
    check_seg(1, 2'b10, 7'h66, "v42_tens");
    check_seg(1, 2'b01, 7'h5B, "v42_units");

    @(negedge clk); i_n2 = '1; i_n2[5] = 1'b0;
    @(posedge clk); #1;
    chk("v5_code", 32'(code2), 32'd5);
    check_seg(1, 2'b10, 7'h00, "v5_tens");
    check_seg(1, 2'b01, 7'h6D, "v5_units");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
